abl17_alu_fault_monitor: RTL and testbench
==========================================

# abl17_alu_fault_monitor

Sequential fault monitor that sits directly downstream of the fault-injectable ALU with its adder/SLL/SRA checkers. Each cycle it qualifies the three checker error flags by the ALU opcode and keeps saturating per-unit error counts. It captures the first erroneous operation and requests a replay to separate transient from permanent faults. A unit that fails `RETRY_LIMIT` consecutive replays is declared permanently faulty and flagged as disabled to the control logic.

## Interface
Parameters:
- `CNT_WIDTH`, 8: width of each per-unit error counter.
- `RETRY_LIMIT`, 2: consecutive failing replays (1..7) before a unit is declared faulty.

Ports:
- `clock`, input, 1: single clock; all state updates on rising edge.
- `reset`, input, 1: reset is asynchronous and active-low (0 = reset).
- `in_valid`, input, 1: ALU result and checker flags valid this cycle.
- `in_opcode`, input, 5: ALU opcode of the sampled operation.
- `in_result`, input, 32: ALU `data_result` of the sampled operation.
- `adder_has_error`, input, 1: adder checker flag.
- `sll_has_error`, input, 1: SLL checker flag.
- `sra_has_error`, input, 1: SRA checker flag.
- `clear`, input, 1: synchronous clear of all logs, counters and disables.
- `out_retry`, output, 1: one-cycle pulse requesting replay of the last operation.
- `out_fault_valid`, output, 1: one-cycle pulse when a unit is newly declared faulty.
- `out_fault_unit`, output, 3: one-hot {sra, sll, adder} of the unit in `out_fault_valid`.
- `unit_disabled`, output, 3: sticky one-hot {sra, sll, adder} permanently faulty units.
- `err_count_adder`, `err_count_sll`, `err_count_sra`, output, CNT_WIDTH each: saturating qualified-error counts.
- `first_err_valid`, output, 1: sticky; first-error capture holds data.
- `first_err_opcode`, output, 5: opcode of first qualified error.
- `first_err_result`, output, 32: ALU result of first qualified error.

## Operation
- Qualification, only when `in_valid`=1: adder error counts for opcodes 0 (ADD) and 1 (SUB); SLL error for opcode 4; SRA error for opcode 5. Flags for other opcodes are ignored. At most one unit qualifies per cycle.
- Counters: a qualified error increments that unit's counter and saturates at all-ones. Counting continues for disabled units.
- First-error capture: on the first qualified error while `first_err_valid`=0, latch opcode and result and set `first_err_valid`. Later errors do not overwrite it.
- FSM states are CHECK (reset state) and RETRY. RETRY holds a recorded unit, a recorded opcode and a 3-bit `retry_cnt`.
- CHECK, qualified error on a non-disabled unit: pulse `out_retry`, record unit and opcode, set `retry_cnt`=1, go to RETRY.
- CHECK, qualified error on a disabled unit: count only; no retry; stay in CHECK.
- RETRY: upstream guarantees the next `in_valid` is the replay. Cycles with `in_valid`=0 keep the state.
- RETRY, replay with the same opcode and a qualified error on the same unit: if `retry_cnt`==`RETRY_LIMIT`, set the `unit_disabled` bit, pulse `out_fault_valid`/`out_fault_unit`, and go to CHECK. Otherwise increment `retry_cnt`, pulse `out_retry` again, and stay in RETRY.
- RETRY, replay with the same opcode and no qualified error: transient fault; go to CHECK with no pulse.
- RETRY, sample with a different opcode: abandon the replay and evaluate the sample with the CHECK rules in the same cycle.
- `clear`=1: zero the counters, the first-error capture and `unit_disabled`, and force CHECK. `clear` has priority over a simultaneous `in_valid`; that sample is dropped.

## Timing
- Reset value of every output is 0. The FSM resets to CHECK with `retry_cnt`=0.
- All outputs are registered. Each output updates on the rising edge that samples the triggering input and is visible the following cycle.
- `out_retry` and `out_fault_valid` are exactly one cycle wide. They are never asserted in the same cycle.
- Asserting reset mid-RETRY aborts immediately (asynchronous). No pulse is emitted after reset is released.
- Back-to-back `in_valid` is supported at full rate. Replay latency upstream is unbounded.

## Test plan
- Reset, then ADD with `adder_has_error`=1, then the replay is clean -> one `out_retry` pulse; `err_count_adder`=1; `first_err_opcode`=0; `unit_disabled`=000; FSM returns to CHECK.
- SRA (opcode 5) errors on the original and on 2 replays with `RETRY_LIMIT`=2 -> 2 `out_retry` pulses, then `out_fault_valid`=1 with `out_fault_unit`=100; `unit_disabled`=100; `err_count_sra`=3.
- AND (opcode 2) with all three flags=1, and ADD with `in_valid`=0 and `adder_has_error`=1 -> no counter change, no pulses.
- `CNT_WIDTH`=2, 5 SLL errors on a disabled SLL unit -> `err_count_sll` saturates at 3; no `out_retry`.
- In RETRY for adder, the next sample is SLL with an error -> replay abandoned; SLL retry pulse; `err_count_sll`=1; recorded unit = SLL.
- `clear` and an erroneous `in_valid` in the same cycle, with `first_err_valid`=1 -> all counters 0, `first_err_valid`=0, no `out_retry`. Separately, asserting reset low mid-RETRY -> all outputs 0 immediately.

Source files
------------

// File: rtl/abl17_alu_fault_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : abl17_alu_fault_monitor                                       |
// | Purpose  : Qualifies ALU checker flags by opcode, counts errors, replays  |
// |            failing operations and declares permanently faulty units.     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module abl17_alu_fault_monitor #(
  parameter int CNT_WIDTH   = 8,
  parameter int RETRY_LIMIT = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [4:0]           in_opcode,
  input  logic [31:0]          in_result,
  input  logic                 adder_has_error,
  input  logic                 sll_has_error,
  input  logic                 sra_has_error,
  input  logic                 clear,
  output logic                 out_retry,
  output logic                 out_fault_valid,
  output logic [2:0]           out_fault_unit,
  output logic [2:0]           unit_disabled,
  output logic [CNT_WIDTH-1:0] err_count_adder,
  output logic [CNT_WIDTH-1:0] err_count_sll,
  output logic [CNT_WIDTH-1:0] err_count_sra,
  output logic                 first_err_valid,
  output logic [4:0]           first_err_opcode,
  output logic [31:0]          first_err_result
);

  localparam logic [4:0] c_op_add = 5'd0;
  localparam logic [4:0] c_op_sub = 5'd1;
  localparam logic [4:0] c_op_sll = 5'd4;
  localparam logic [4:0] c_op_sra = 5'd5;
  localparam logic [2:0] c_retry_limit = 3'(RETRY_LIMIT);
  localparam logic [CNT_WIDTH-1:0] c_cnt_one = CNT_WIDTH'(1);

  typedef enum logic [0:0] {
    CHECK = 1'b0,
    RETRY = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [2:0]             r_rec_unit;
  logic [2:0]             w_rec_unit_nxt;
  logic [4:0]             r_rec_opcode;
  logic [4:0]             w_rec_opcode_nxt;
  logic [2:0]             r_retry_cnt;
  logic [2:0]             w_retry_cnt_nxt;
  logic                   r_retry;
  logic                   w_retry_nxt;
  logic                   r_fault_valid;
  logic                   w_fault_valid_nxt;
  logic [2:0]             r_fault_unit;
  logic [2:0]             w_fault_unit_nxt;
  logic [2:0]             r_unit_disabled;
  logic [2:0]             w_unit_disabled_nxt;
  logic [CNT_WIDTH-1:0]   r_err_cnt [3];
  logic                   r_first_valid;
  logic [4:0]             r_first_opcode;
  logic [31:0]            r_first_result;

  logic [2:0]             w_q_unit;
  logic                   w_q_any;
  logic                   w_start_retry;
  logic                   w_replay;

  // One-hot {sra, sll, adder}; opcode decode keeps at most one bit set.
  assign w_q_unit[0] = in_valid && adder_has_error &&
                       ((in_opcode == c_op_add) || (in_opcode == c_op_sub));
  assign w_q_unit[1] = in_valid && sll_has_error && (in_opcode == c_op_sll);
  assign w_q_unit[2] = in_valid && sra_has_error && (in_opcode == c_op_sra);
  assign w_q_any     = |w_q_unit;

  assign w_start_retry = w_q_any && ((w_q_unit & r_unit_disabled) == 3'b000);
  assign w_replay      = (r_state == RETRY) && in_valid && (in_opcode == r_rec_opcode);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state         <= CHECK;
      r_rec_unit      <= 3'b000;
      r_rec_opcode    <= 5'd0;
      r_retry_cnt     <= 3'd0;
      r_retry         <= 1'b0;
      r_fault_valid   <= 1'b0;
      r_fault_unit    <= 3'b000;
      r_unit_disabled <= 3'b000;
    end else begin
      r_state         <= w_state_nxt;
      r_rec_unit      <= w_rec_unit_nxt;
      r_rec_opcode    <= w_rec_opcode_nxt;
      r_retry_cnt     <= w_retry_cnt_nxt;
      r_retry         <= w_retry_nxt;
      r_fault_valid   <= w_fault_valid_nxt;
      r_fault_unit    <= w_fault_unit_nxt;
      r_unit_disabled <= w_unit_disabled_nxt;
    end
  end

  always_comb begin
    w_state_nxt         = r_state;
    w_rec_unit_nxt      = r_rec_unit;
    w_rec_opcode_nxt    = r_rec_opcode;
    w_retry_cnt_nxt     = r_retry_cnt;
    w_retry_nxt         = 1'b0;
    w_fault_valid_nxt   = 1'b0;
    w_fault_unit_nxt    = 3'b000;
    w_unit_disabled_nxt = r_unit_disabled;
    if (clear) begin
      w_state_nxt         = CHECK;
      w_rec_unit_nxt      = 3'b000;
      w_rec_opcode_nxt    = 5'd0;
      w_retry_cnt_nxt     = 3'd0;
      w_unit_disabled_nxt = 3'b000;
    end else if (w_replay) begin
      // Same opcode means a qualified error can only be on the recorded unit.
      if (w_q_unit == r_rec_unit) begin
        if (r_retry_cnt == c_retry_limit) begin
          w_unit_disabled_nxt = r_unit_disabled | r_rec_unit;
          w_fault_valid_nxt   = 1'b1;
          w_fault_unit_nxt    = r_rec_unit;
          w_state_nxt         = CHECK;
          w_retry_cnt_nxt     = 3'd0;
        end else begin
          w_retry_cnt_nxt = r_retry_cnt + 3'd1;
          w_retry_nxt     = 1'b1;
        end
      end else begin
        w_state_nxt     = CHECK;
        w_retry_cnt_nxt = 3'd0;
      end
    end else if (in_valid) begin
      // Fresh sample in CHECK, or an abandoned replay treated as fresh.
      w_state_nxt     = CHECK;
      w_retry_cnt_nxt = 3'd0;
      if (w_start_retry) begin
        w_state_nxt      = RETRY;
        w_rec_unit_nxt   = w_q_unit;
        w_rec_opcode_nxt = in_opcode;
        w_retry_cnt_nxt  = 3'd1;
        w_retry_nxt      = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) r_err_cnt[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < 3; i++) r_err_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (w_q_unit[i] && !(&r_err_cnt[i])) r_err_cnt[i] <= r_err_cnt[i] + c_cnt_one;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_first_valid  <= 1'b0;
      r_first_opcode <= 5'd0;
      r_first_result <= 32'd0;
    end else if (clear) begin
      r_first_valid  <= 1'b0;
      r_first_opcode <= 5'd0;
      r_first_result <= 32'd0;
    end else if (w_q_any && !r_first_valid) begin
      r_first_valid  <= 1'b1;
      r_first_opcode <= in_opcode;
      r_first_result <= in_result;
    end
  end

  assign out_retry        = r_retry;
  assign out_fault_valid  = r_fault_valid;
  assign out_fault_unit   = r_fault_unit;
  assign unit_disabled    = r_unit_disabled;
  assign err_count_adder  = r_err_cnt[0];
  assign err_count_sll    = r_err_cnt[1];
  assign err_count_sra    = r_err_cnt[2];
  assign first_err_valid  = r_first_valid;
  assign first_err_opcode = r_first_opcode;
  assign first_err_result = r_first_result;

endmodule
`default_nettype wire

// File: tb/tb_abl17_alu_fault_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_abl17_alu_fault_monitor                                    |
// | Purpose  : Directed vector table plus randomized run against a model.    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_abl17_alu_fault_monitor;

  localparam int CNT_WIDTH   = 2;
  localparam int RETRY_LIMIT = 2;
  localparam int CNT_MAX     = (1 << CNT_WIDTH) - 1;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic [4:0]           in_opcode;
  logic [31:0]          in_result;
  logic                 adder_has_error;
  logic                 sll_has_error;
  logic                 sra_has_error;
  logic                 clear;
  logic                 out_retry;
  logic                 out_fault_valid;
  logic [2:0]           out_fault_unit;
  logic [2:0]           unit_disabled;
  logic [CNT_WIDTH-1:0] err_count_adder;
  logic [CNT_WIDTH-1:0] err_count_sll;
  logic [CNT_WIDTH-1:0] err_count_sra;
  logic                 first_err_valid;
  logic [4:0]           first_err_opcode;
  logic [31:0]          first_err_result;

  int n_err = 0;
  int n_chk = 0;

  abl17_alu_fault_monitor #(.CNT_WIDTH(CNT_WIDTH), .RETRY_LIMIT(RETRY_LIMIT)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_opcode(in_opcode),
    .in_result(in_result), .adder_has_error(adder_has_error),
    .sll_has_error(sll_has_error), .sra_has_error(sra_has_error), .clear(clear),
    .out_retry(out_retry), .out_fault_valid(out_fault_valid),
    .out_fault_unit(out_fault_unit), .unit_disabled(unit_disabled),
    .err_count_adder(err_count_adder), .err_count_sll(err_count_sll),
    .err_count_sra(err_count_sra), .first_err_valid(first_err_valid),
    .first_err_opcode(first_err_opcode), .first_err_result(first_err_result)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        clr;
    logic        vld;
    logic [4:0]  op;
    logic [2:0]  fl;      // {sra, sll, adder}
    logic        e_retry;
    logic        e_fv;
    logic [2:0]  e_fu;
    logic [2:0]  e_dis;
    int          e_ca;
    int          e_cl;
    int          e_cr;
    logic        e_fev;
    logic [4:0]  e_feop;
    logic [31:0] e_fer;
  } vec_t;

  vec_t tbl [16];

  // Reference model state
  int          m_cnt [3];
  bit [2:0]    m_dis;
  bit          m_in_retry;
  int          m_rec_unit;
  int          m_rec_op;
  int          m_tries;
  bit          m_fev;
  int          m_feop;
  logic [31:0] m_fer;
  bit          m_retry;
  bit          m_fv;
  bit [2:0]    m_fu;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic e_retry, input logic e_fv,
                           input logic [2:0] e_fu, input logic [2:0] e_dis,
                           input int e_ca, input int e_cl, input int e_cr,
                           input logic e_fev, input logic [4:0] e_feop,
                           input logic [31:0] e_fer);
    chk({tag, ".retry"}, 32'(out_retry), 32'(e_retry));
    chk({tag, ".fault_valid"}, 32'(out_fault_valid), 32'(e_fv));
    chk({tag, ".fault_unit"}, 32'(out_fault_unit), 32'(e_fu));
    chk({tag, ".disabled"}, 32'(unit_disabled), 32'(e_dis));
    chk({tag, ".cnt_adder"}, 32'(err_count_adder), 32'(e_ca));
    chk({tag, ".cnt_sll"}, 32'(err_count_sll), 32'(e_cl));
    chk({tag, ".cnt_sra"}, 32'(err_count_sra), 32'(e_cr));
    chk({tag, ".first_valid"}, 32'(first_err_valid), 32'(e_fev));
    chk({tag, ".first_op"}, 32'(first_err_opcode), 32'(e_feop));
    chk({tag, ".first_res"}, first_err_result, e_fer);
  endtask

  task automatic apply(input logic c, input logic v, input logic [4:0] op,
                       input logic [2:0] fl, input logic [31:0] res);
    @(negedge clock);
    clear = c; in_valid = v; in_opcode = op; in_result = res;
    {sra_has_error, sll_has_error, adder_has_error} = fl;
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    m_dis = 3'b000; m_in_retry = 0; m_rec_unit = -1; m_rec_op = 0; m_tries = 0;
    m_fev = 0; m_feop = 0; m_fer = 32'd0; m_retry = 0; m_fv = 0; m_fu = 3'b000;
  endtask

  task automatic model_step(input bit c, input bit v, input int op, input bit [2:0] fl,
                            input logic [31:0] res);
    int  u;
    bit  handled;
    u = -1;
    m_retry = 0; m_fv = 0; m_fu = 3'b000;
    if (c) begin
      for (int i = 0; i < 3; i++) m_cnt[i] = 0;
      m_dis = 3'b000; m_fev = 0; m_feop = 0; m_fer = 32'd0; m_in_retry = 0;
      return;
    end
    if (v) begin
      if ((op == 0 || op == 1) && fl[0]) u = 0;
      else if (op == 4 && fl[1]) u = 1;
      else if (op == 5 && fl[2]) u = 2;
    end
    if (u >= 0) begin
      if (m_cnt[u] < CNT_MAX) m_cnt[u]++;
      if (!m_fev) begin m_fev = 1; m_feop = op; m_fer = res; end
    end
    handled = 0;
    if (m_in_retry && v && op == m_rec_op) begin
      handled = 1;
      if (u == m_rec_unit) begin
        if (m_tries == RETRY_LIMIT) begin
          m_dis[u] = 1'b1; m_fv = 1; m_fu[u] = 1'b1; m_in_retry = 0;
        end else begin
          m_tries++; m_retry = 1;
        end
      end else begin
        m_in_retry = 0;
      end
    end
    if (!handled && v) begin
      m_in_retry = 0;
      if (u >= 0 && !m_dis[u]) begin
        m_retry = 1; m_in_retry = 1; m_rec_unit = u; m_rec_op = op; m_tries = 1;
      end
    end
  endtask

  initial begin
    logic [31:0] r0;
    logic [31:0] rd;
    int          ops [7];
    r0 = 32'hA000_0000;
    rd = 32'hA000_000D;
    //            clr vld op fl      rt fv fu      dis     ca cl cr fev feop fer
    tbl[0]  = '{1'b0, 1'b1, 5'd0, 3'b001, 1'b1, 1'b0, 3'b000, 3'b000, 1, 0, 0, 1'b1, 5'd0, r0};
    tbl[1]  = '{1'b0, 1'b1, 5'd0, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 1, 0, 0, 1'b1, 5'd0, r0};
    tbl[2]  = '{1'b0, 1'b1, 5'd5, 3'b100, 1'b1, 1'b0, 3'b000, 3'b000, 1, 0, 1, 1'b1, 5'd0, r0};
    tbl[3]  = '{1'b0, 1'b1, 5'd5, 3'b100, 1'b1, 1'b0, 3'b000, 3'b000, 1, 0, 2, 1'b1, 5'd0, r0};
    tbl[4]  = '{1'b0, 1'b0, 5'd5, 3'b100, 1'b0, 1'b0, 3'b000, 3'b000, 1, 0, 2, 1'b1, 5'd0, r0};
    tbl[5]  = '{1'b0, 1'b1, 5'd5, 3'b100, 1'b0, 1'b1, 3'b100, 3'b100, 1, 0, 3, 1'b1, 5'd0, r0};
    tbl[6]  = '{1'b0, 1'b1, 5'd2, 3'b111, 1'b0, 1'b0, 3'b000, 3'b100, 1, 0, 3, 1'b1, 5'd0, r0};
    tbl[7]  = '{1'b0, 1'b0, 5'd0, 3'b001, 1'b0, 1'b0, 3'b000, 3'b100, 1, 0, 3, 1'b1, 5'd0, r0};
    tbl[8]  = '{1'b0, 1'b1, 5'd5, 3'b100, 1'b0, 1'b0, 3'b000, 3'b100, 1, 0, 3, 1'b1, 5'd0, r0};
    tbl[9]  = '{1'b0, 1'b1, 5'd0, 3'b001, 1'b1, 1'b0, 3'b000, 3'b100, 2, 0, 3, 1'b1, 5'd0, r0};
    tbl[10] = '{1'b0, 1'b1, 5'd4, 3'b010, 1'b1, 1'b0, 3'b000, 3'b100, 2, 1, 3, 1'b1, 5'd0, r0};
    tbl[11] = '{1'b0, 1'b1, 5'd4, 3'b010, 1'b1, 1'b0, 3'b000, 3'b100, 2, 2, 3, 1'b1, 5'd0, r0};
    tbl[12] = '{1'b1, 1'b1, 5'd1, 3'b001, 1'b0, 1'b0, 3'b000, 3'b000, 0, 0, 0, 1'b0, 5'd0, 32'd0};
    tbl[13] = '{1'b0, 1'b1, 5'd4, 3'b010, 1'b1, 1'b0, 3'b000, 3'b000, 0, 1, 0, 1'b1, 5'd4, rd};
    tbl[14] = '{1'b0, 1'b1, 5'd4, 3'b010, 1'b1, 1'b0, 3'b000, 3'b000, 0, 2, 0, 1'b1, 5'd4, rd};
    tbl[15] = '{1'b0, 1'b1, 5'd4, 3'b010, 1'b0, 1'b1, 3'b010, 3'b010, 0, 3, 0, 1'b1, 5'd4, rd};

    reset = 1'b0; clear = 1'b0; in_valid = 1'b0; in_opcode = 5'd0; in_result = 32'd0;
    adder_has_error = 1'b0; sll_has_error = 1'b0; sra_has_error = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_all("reset", 0, 0, 3'b000, 3'b000, 0, 0, 0, 0, 5'd0, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 16; i++) begin
      apply(tbl[i].clr, tbl[i].vld, tbl[i].op, tbl[i].fl, r0 + 32'(i));
      check_all($sformatf("vec%0d", i), tbl[i].e_retry, tbl[i].e_fv, tbl[i].e_fu,
                tbl[i].e_dis, tbl[i].e_ca, tbl[i].e_cl, tbl[i].e_cr, tbl[i].e_fev,
                tbl[i].e_feop, tbl[i].e_fer);
    end

    // Disabled SLL unit: errors still count (saturating) but never retry.
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, 1'b1, 5'd4, 3'b010, 32'h5555_0000 + 32'(i));
      check_all($sformatf("sat%0d", i), 0, 0, 3'b000, 3'b010, 0, 3, 0, 1, 5'd4, rd);
    end

    // Reset asserted while a replay is pending clears everything at once.
    apply(1'b0, 1'b1, 5'd0, 3'b001, 32'h7777_0000);
    check_all("pre_rst", 1, 0, 3'b000, 3'b010, 1, 3, 0, 1, 5'd4, rd);
    @(negedge clock);
    in_valid = 1'b0; adder_has_error = 1'b0; sll_has_error = 1'b0;
    #2 reset = 1'b0;
    #1;
    check_all("async_rst", 0, 0, 3'b000, 3'b000, 0, 0, 0, 0, 5'd0, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b0, 5'd0, 3'b000, 32'd0);
      check_all($sformatf("post_rst%0d", i), 0, 0, 3'b000, 3'b000, 0, 0, 0, 0, 5'd0, 32'd0);
    end

    // Randomized run against the reference model.
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    ops = '{0, 1, 2, 3, 4, 5, 0};
    for (int n = 0; n < 3000; n++) begin
      bit          c;
      bit          v;
      int          op;
      bit [2:0]    fl;
      logic [31:0] res;
      c = ($urandom_range(0, 49) == 0);
      v = ($urandom_range(0, 9) < 7);
      if (m_in_retry && $urandom_range(0, 9) < 7) op = m_rec_op;
      else begin
        ops[6] = int'($urandom_range(0, 31));
        op = ops[$urandom_range(0, 6)];
      end
      for (int b = 0; b < 3; b++) fl[b] = ($urandom_range(0, 99) < 45);
      res = $urandom;
      apply(c, v, 5'(op), fl, res);
      model_step(c, v, op, fl, res);
      check_all($sformatf("rnd%0d", n), m_retry, m_fv, m_fu, m_dis, m_cnt[0], m_cnt[1],
                m_cnt[2], m_fev, 5'(m_feop), m_fer);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
